// File: rtl/cache_fill_fsm_if.sv
// Bundle between the cache miss logic, the cache arrays and the memory port
// as seen by the block-fill sequencer. The "master" modport is the sequencer
// side; "slave" is the cache pipeline / arrays / memory environment.
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  wt_req;
  logic [ADDR_WIDTH-1:0] wt_addr;
  logic [15:0]           wt_data;
  logic                  wt_ack;
  logic                  fsm_busy;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [15:0]           fill_data;
  logic                  memory_enable;
  logic                  memory_wr;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [15:0]           memory_data_in;
  logic [15:0]           memory_data_out;
  logic                  memory_data_valid;

  modport master (
    input  miss_detected, miss_address, wt_req, wt_addr, wt_data,
           memory_data_out, memory_data_valid,
    output wt_ack, fsm_busy, write_data_array, write_tag_array, fill_addr,
           fill_data, memory_enable, memory_wr, memory_address, memory_data_in
  );

  modport slave (
    output miss_detected, miss_address, wt_req, wt_addr, wt_data,
           memory_data_out, memory_data_valid,
    input  wt_ack, fsm_busy, write_data_array, write_tag_array, fill_addr,
           fill_data, memory_enable, memory_wr, memory_address, memory_data_in
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache block-fill sequencer. On a miss it pipelines BLOCK_WORDS reads for the
// aligned block, writes each in-order response into the data array, writes the
// tag with the last word and then returns to IDLE. When idle it forwards
// single-cycle write-through requests straight to memory.
// Outputs are combinational from state and inputs because the stall and the
// write-through acknowledge must appear in the same cycle as the request.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input logic              clk,
  input logic              rst,
  cache_fill_fsm_if.master bus
);

  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;  // issue counter reaches BLOCK_WORDS
  localparam int RET_W = $clog2(BLOCK_WORDS);      // return counter stops at BLOCK_WORDS-1

  localparam logic [CNT_W-1:0]      ISSUE_LAST = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]      ISSUE_ONE  = CNT_W'(1);
  localparam logic [RET_W-1:0]      RET_LAST   = RET_W'(BLOCK_WORDS - 1);
  localparam logic [RET_W-1:0]      RET_ONE    = RET_W'(1);
  // Clears the byte-in-block offset bits (log2 of 2*BLOCK_WORDS bytes).
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK  = ~(ADDR_WIDTH'(2 * BLOCK_WORDS - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      issue_cnt_r, issue_cnt_s;
  logic [RET_W-1:0]      ret_cnt_r, ret_cnt_s;
  logic [ADDR_WIDTH-1:0] base_r, base_s;
  logic                  last_ret_s;

  // Word offset inside the block; base has its offset bits clear, so no carry
  // ever leaves the block.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [CNT_W-1:0]      cnt
  );
    return base + ADDR_WIDTH'({cnt, 1'b0});
  endfunction

  // State, counters and latched block base.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      issue_cnt_r <= '0;
      ret_cnt_r   <= '0;
      base_r      <= '0;
    end else begin
      state_r     <= state_s;
      issue_cnt_r <= issue_cnt_s;
      ret_cnt_r   <= ret_cnt_s;
      base_r      <= base_s;
    end
  end

  // Next state: issue sequencing and in-order return counting.
  always_comb begin
    state_s     = state_r;
    issue_cnt_s = issue_cnt_r;
    ret_cnt_s   = ret_cnt_r;
    base_s      = base_r;
    last_ret_s  = bus.memory_data_valid && (ret_cnt_r == RET_LAST);
    case (state_r)
      IDLE: begin
        if (bus.miss_detected) begin
          state_s     = FILL;
          base_s      = bus.miss_address & BASE_MASK;
          issue_cnt_s = '0;
          ret_cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        issue_cnt_s = issue_cnt_r + ISSUE_ONE;
        if (bus.memory_data_valid) begin
          ret_cnt_s = ret_cnt_r + RET_ONE;
        end else begin
          ret_cnt_s = ret_cnt_r;
        end
        if (last_ret_s) begin
          state_s = IDLE;
        end else if (issue_cnt_r == ISSUE_LAST) begin
          state_s = WAIT;
        end else begin
          state_s = FILL;
        end
      end
      WAIT: begin
        if (bus.memory_data_valid) begin
          ret_cnt_s = ret_cnt_r + RET_ONE;
        end else begin
          ret_cnt_s = ret_cnt_r;
        end
        if (last_ret_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs: stall, memory requests, write-through ack and array writes.
  // Everything is held low while rst is asserted so a fill aborts at once.
  always_comb begin
    bus.fsm_busy         = 1'b0;
    bus.wt_ack           = 1'b0;
    bus.memory_enable    = 1'b0;
    bus.memory_wr        = 1'b0;
    bus.memory_address   = '0;
    bus.memory_data_in   = 16'h0000;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.fill_addr        = '0;
    bus.fill_data        = 16'h0000;
    if (!rst) begin
      case (state_r)
        IDLE: begin
          bus.fsm_busy = bus.miss_detected;
          if (!bus.miss_detected && bus.wt_req) begin
            bus.memory_enable  = 1'b1;
            bus.memory_wr      = 1'b1;
            bus.memory_address = bus.wt_addr;
            bus.memory_data_in = bus.wt_data;
            bus.wt_ack         = 1'b1;
          end else begin
            bus.wt_ack = 1'b0;
          end
        end
        FILL: begin
          bus.fsm_busy       = 1'b1;
          bus.memory_enable  = 1'b1;
          bus.memory_address = word_addr(base_r, issue_cnt_r);
        end
        WAIT: begin
          bus.fsm_busy = 1'b1;
        end
        default: begin
          bus.fsm_busy = 1'b0;
        end
      endcase
      if ((state_r == FILL || state_r == WAIT) && bus.memory_data_valid) begin
        bus.write_data_array = 1'b1;
        bus.fill_data        = bus.memory_data_out;
        bus.fill_addr        = word_addr(base_r, CNT_W'(ret_cnt_r));
        bus.write_tag_array  = last_ret_s;
      end else begin
        bus.write_data_array = 1'b0;
      end
    end else begin
      bus.fsm_busy = 1'b0;
    end
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Requester side of the multicycle memory interface: on a cache miss, fetches one 16-byte block (8 words) by pipelining 8 reads, then collects the 8 in-order responses qualified by memory data_valid.
- Writes each returned word into the cache data array and updates the tag array on the final word.
- Also forwards single-cycle write-through requests to memory when no fill is in progress.
- Sits between the cache pipeline (I/D cache miss logic) and the memory port.

Parameters:
- ADDR_WIDTH, 16, byte address width; must match the memory.
- BLOCK_WORDS, 8, 16-bit words per cache block; power of two.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- miss_detected  input  1  cache miss request, sampled in IDLE
- miss_address  input  ADDR_WIDTH  byte address of the missing access
- wt_req  input  1  write-through request
- wt_addr  input  ADDR_WIDTH  write-through byte address (bit 0 is 0)
- wt_data  input  16  write-through data
- wt_ack  output  1  write-through accepted this cycle
- fsm_busy  output  1  stall to cache pipeline
- write_data_array  output  1  write fill_data to data array at fill_addr
- write_tag_array  output  1  write tag for the block base address
- fill_addr  output  ADDR_WIDTH  byte address of the word being written to the cache
- fill_data  output  16  word being written to the cache
- memory_enable  output  1  memory request
- memory_wr  output  1  1 = write, 0 = read
- memory_address  output  ADDR_WIDTH  memory byte address
- memory_data_in  output  16  memory write data
- memory_data_out  input  16  memory read data
- memory_data_valid  input  1  memory read data valid

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- Reset state: state=IDLE, counters=0, latched base=0. All request, strobe and data outputs are 0 while in IDLE with no request.
- Reset mid-fill aborts immediately: next state IDLE, no further writes or requests. The memory is reset in the same cycle, so its in-flight pipeline is flushed.
- States: IDLE, FILL, WAIT.
- Block base: base = miss_address with the low log2(2*BLOCK_WORDS) bits cleared. It is latched on the IDLE->FILL transition.
- Counters:
  - issue_cnt, range 0..BLOCK_WORDS.
  - ret_cnt, range 0..BLOCK_WORDS-1.
  - Each word offset is cnt<<1 added to base, so addresses never leave the block.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the pipeline stalls in the miss cycle).
  - If miss_detected: go to FILL; issue_cnt=0, ret_cnt=0. No memory request this cycle.
  - Else if wt_req: memory_enable=1, memory_wr=1, memory_address=wt_addr, memory_data_in=wt_data, wt_ack=1, all in the same cycle.
  - miss_detected and wt_req together: miss wins, wt_ack=0. The requester must hold wt_req.
- FILL:
  - fsm_busy=1.
  - Each cycle: memory_enable=1, memory_wr=0, memory_address=base+(issue_cnt<<1); then issue_cnt++.
  - After the BLOCK_WORDS-th issue, go to WAIT.
- WAIT: fsm_busy=1; no memory requests.
- Response handling in FILL or WAIT: if memory_data_valid, then
  - write_data_array=1, fill_data=memory_data_out, fill_addr=base+(ret_cnt<<1), ret_cnt++;
  - on the last word (ret_cnt==BLOCK_WORDS-1), write_tag_array=1 in the same cycle and the next state is IDLE.
- Returns are in order and counted only by memory_data_valid; no fixed latency is assumed.
- memory_data_valid in IDLE is ignored: no array writes.
- wt_req is never acknowledged in FILL or WAIT.
- Nominal timing with 4-cycle memory latency and BLOCK_WORDS=8:
  - Miss at cycle 0; reads issued cycles 1-8.
  - Valid returns cycles 5-12; tag write at cycle 12.
  - IDLE and fsm_busy=0 at cycle 13, giving 13 stall cycles per miss.
- fill_data and fill_addr are don't-care when write_data_array=0; drive them to 0.

Test Plan:
- Reset, then miss_address=0x1236 -> base 0x1230. Reads to 0x1230,0x1232,...,0x123E on cycles 1-8. write_data_array on cycles 5-12 with mem[0x1230..0x123E] at matching fill_addr. write_tag_array only on cycle 12. fsm_busy high cycles 0-12, low on cycle 13.
- Miss at 0xFFFE -> base 0xFFF0. Addresses 0xFFF0..0xFFFE with no wrap past 0xFFFF. Tag write on the 8th return.
- wt_req addr 0x0040 data 0xBEEF in IDLE -> same-cycle enable=1, wr=1, wt_ack=1. A later fill covering 0x0040 returns 0xBEEF.
- miss_detected and wt_req in the same IDLE cycle -> wt_ack=0 through the whole fill. The write is accepted at cycle 13 if still held; no memory_wr=1 before then.
- rst asserted at cycle 6 of a fill -> IDLE next cycle. No write_tag_array, no further memory_enable. A new miss afterwards completes normally.
- Spurious memory_data_valid pulse in IDLE -> write_data_array and write_tag_array stay 0, state stays IDLE.
